// File: rtl/aes_cbc_out_pkg.sv
// Shared types and constants for the AES CBC decryption output stage.
package aes_cbc_out_pkg;

   localparam int unsigned NWords = 4;
   localparam int unsigned IdxW   = 2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFill  = 2'd1,
      StDrain = 2'd2
   } state_e;

endpackage

// File: rtl/aes_cbc_wreg.sv
// Four-word register with indexed write, full-block load and block readout.
// An indexed write wins over a block load for the same word.
module aes_cbc_wreg
   import aes_cbc_out_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          we_i,
   input  logic [IdxW-1:0]               widx_i,
   input  logic [W-1:0]                  wdata_i,
   input  logic                          ld_i,
   input  logic [NWords-1:0][W-1:0]      ld_data_i,
   output logic [NWords-1:0][W-1:0]      q_o
);

   logic [NWords-1:0][W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (ld_i) q_d = ld_data_i;
      if (we_i) q_d[widx_i] = wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/aes_cbc_out.sv
// CBC output stage: captures core column words, XORs with chaining value, drains plaintext.
// Define AES_CBC_OUT_ECB_EN to add the ecb_i bypass input.
module aes_cbc_out
   import aes_cbc_out_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   input  logic            dvld_i,
   input  logic [IdxW-1:0] dcol_i,
   input  logic [W-1:0]    din_i,
   input  logic            ct_we_i,
   input  logic [IdxW-1:0] ct_idx_i,
   input  logic [W-1:0]    ct_in_i,
   input  logic            iv_we_i,
   input  logic [IdxW-1:0] iv_idx_i,
   input  logic [W-1:0]    iv_in_i,
`ifdef AES_CBC_OUT_ECB_EN
   input  logic            ecb_i,
`endif
   output logic [W-1:0]    dout_o,
   output logic            dout_vld_o,
   input  logic            dout_rdy_i,
   output logic            full_o,
   output logic            ovf_o
);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(NWords - 1);

   state_e                   state_q, state_d;
   logic [IdxW-1:0]          cnt_q, cnt_d, rptr_q, rptr_d;
   logic                     ovf_q, ovf_d;
   logic [NWords-1:0][W-1:0] prev_q, cur_q, pt_q;
   logic                     ecb, cap, last, hs;
   logic [W-1:0]             pt_wdata;

`ifdef AES_CBC_OUT_ECB_EN
   assign ecb = ecb_i;
`else
   assign ecb = 1'b0;
`endif

   // Words arriving during DRAIN are not captured; they only flag overflow.
   assign cap  = en_i && dvld_i && (state_q != StDrain);
   assign last = cap && (state_q == StFill) && (cnt_q == LastIdx);
   assign hs   = (state_q == StDrain) && dout_rdy_i;

   assign pt_wdata = ecb ? din_i : (din_i ^ prev_q[dcol_i]);

   aes_cbc_wreg #(.W(W)) u_pt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (cap),
      .widx_i    (dcol_i),
      .wdata_i   (pt_wdata),
      .ld_i      (1'b0),
      .ld_data_i ('0),
      .q_o       (pt_q)
   );

   aes_cbc_wreg #(.W(W)) u_cur (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (en_i && ct_we_i),
      .widx_i    (ct_idx_i),
      .wdata_i   (ct_in_i),
      .ld_i      (1'b0),
      .ld_data_i ('0),
      .q_o       (cur_q)
   );

   // prev loads the pre-write cur; an IV write to the same word takes priority.
   aes_cbc_wreg #(.W(W)) u_prev (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (en_i && iv_we_i),
      .widx_i    (iv_idx_i),
      .wdata_i   (iv_in_i),
      .ld_i      (last && !ecb),
      .ld_data_i (cur_q),
      .q_o       (prev_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rptr_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rptr_q  <= rptr_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rptr_d  = rptr_q;
      ovf_d   = ovf_q | (en_i && dvld_i && (state_q == StDrain));
      unique case (state_q)
         StIdle: begin
            if (cap) begin
               state_d = StFill;
               cnt_d   = IdxW'(1);
            end
         end
         StFill: begin
            if (cap) begin
               cnt_d = cnt_q + IdxW'(1);
               if (cnt_q == LastIdx) begin
                  state_d = StDrain;
                  rptr_d  = '0;
               end
            end
         end
         StDrain: begin
            if (hs) begin
               rptr_d = rptr_q + IdxW'(1);
               if (rptr_q == LastIdx) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dout_vld_o = (state_q == StDrain);
      full_o     = (state_q != StIdle);
      dout_o     = (state_q == StDrain) ? pt_q[rptr_q] : '0;
      ovf_o      = ovf_q;
   end

endmodule

// File: tb/tb_aes_cbc_out.sv
// Directed self-checking bench for aes_cbc_out with hand-computed plaintext vectors.
module tb_aes_cbc_out;

   typedef logic [31:0] blk_t [4];

   logic        clk = 1'b0;
   logic        rst, en, dvld, ct_we, iv_we, dout_rdy, ecb;
   logic [1:0]  dcol, ct_idx, iv_idx;
   logic [31:0] din, ct_in, iv_in, dout;
   logic        dout_vld, full, ovf;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   aes_cbc_out #(.W(32)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .dvld_i     (dvld),
      .dcol_i     (dcol),
      .din_i      (din),
      .ct_we_i    (ct_we),
      .ct_idx_i   (ct_idx),
      .ct_in_i    (ct_in),
      .iv_we_i    (iv_we),
      .iv_idx_i   (iv_idx),
      .iv_in_i    (iv_in),
`ifdef AES_CBC_OUT_ECB_EN
      .ecb_i      (ecb),
`endif
      .dout_o     (dout),
      .dout_vld_o (dout_vld),
      .dout_rdy_i (dout_rdy),
      .full_o     (full),
      .ovf_o      (ovf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic load_iv(input blk_t v);
      for (int i = 0; i < 4; i++) begin
         iv_we = 1'b1; iv_idx = 2'(i); iv_in = v[i];
         @(posedge clk); @(negedge clk);
      end
      iv_we = 1'b0;
   endtask

   task automatic load_ct(input blk_t v);
      for (int i = 0; i < 4; i++) begin
         ct_we = 1'b1; ct_idx = 2'(i); ct_in = v[i];
         @(posedge clk); @(negedge clk);
      end
      ct_we = 1'b0;
   endtask

   task automatic feed(input blk_t d, input int n);
      for (int i = 0; i < n; i++) begin
         dvld = 1'b1; dcol = 2'(i); din = d[i];
         @(posedge clk); @(negedge clk);
         if (i == 0) check_eq("full_rise", 32'(full), 32'd1);
      end
      dvld = 1'b0;
      if (n == 4) check_eq("vld_rise", 32'(dout_vld), 32'd1);
   endtask

   task automatic drain(input blk_t exp, input bit toggle);
      int  k = 0;
      bit  hs;
      for (int it = 0; it < 16 && k < 4; it++) begin
         check_eq("drain_vld", 32'(dout_vld), 32'd1);
         check_eq($sformatf("drain_w%0d", k), dout, exp[k]);
         dout_rdy = toggle ? (it % 2 == 0) : 1'b1;
         hs = dout_rdy && dout_vld;
         @(posedge clk); @(negedge clk);
         if (hs) k++;
      end
      dout_rdy = 1'b0;
      check_eq("drain_count", 32'(k), 32'd4);
      check_eq("full_fall", 32'(full), 32'd0);
      check_eq("vld_fall", 32'(dout_vld), 32'd0);
   endtask

   initial begin
      blk_t v, e;
      rst = 1'b1; en = 1'b1; dvld = 1'b0; ct_we = 1'b0; iv_we = 1'b0; dout_rdy = 1'b0;
      ecb = 1'b0; dcol = '0; ct_idx = '0; iv_idx = '0; din = '0; ct_in = '0; iv_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_dout", dout, 32'h0);
      check_eq("rst_vld", 32'(dout_vld), 32'd0);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);

      // IV chaining on the first block
      v = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
      load_iv(v);
      v = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};
      feed(v, 4);
      e = '{32'hfffefdfc, 32'hfbfaf9f8, 32'hf7f6f5f4, 32'hf3f2f1f0};
      drain(e, 1'b0);

      // Ciphertext of block 1 chains into block 2
      v = '{32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5};
      load_ct(v);
      v = '{32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
      feed(v, 4);
      drain(v, 1'b0);
      v = '{32'h0, 32'h0, 32'h0, 32'h0};
      feed(v, 4);
      e = '{32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5};
      drain(e, 1'b0);

      // Backpressure: ready toggling 1,0,1,0
      v = '{32'h1, 32'h2, 32'h3, 32'h4};
      feed(v, 4);
      e = '{32'ha5a5a5a4, 32'ha5a5a5a7, 32'ha5a5a5a6, 32'ha5a5a5a1};
      drain(e, 1'b1);

      // Core word during drain is dropped and flags overflow
      v = '{32'h0, 32'h0, 32'h0, 32'h0};
      feed(v, 4);
      dvld = 1'b1; dcol = 2'd0; din = 32'hdeadbeef;
      @(posedge clk); @(negedge clk);
      dvld = 1'b0;
      check_eq("ovf_set", 32'(ovf), 32'd1);
      check_eq("ovf_dout_hold", dout, 32'ha5a5a5a5);
      e = '{32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5};
      drain(e, 1'b0);
      repeat (3) @(negedge clk);
      check_eq("ovf_sticky", 32'(ovf), 32'd1);

      // Reset mid-fill aborts the block and clears chaining state
      v = '{32'h0f0f0f0f, 32'h0f0f0f0f, 32'h0f0f0f0f, 32'h0f0f0f0f};
      feed(v, 2);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      check_eq("mrst_dout", dout, 32'h0);
      check_eq("mrst_vld", 32'(dout_vld), 32'd0);
      check_eq("mrst_full", 32'(full), 32'd0);
      check_eq("mrst_ovf", 32'(ovf), 32'd0);
      feed(v, 4);
      drain(v, 1'b0);

`ifdef AES_CBC_OUT_ECB_EN
      // ECB bypass leaves the chaining register untouched
      v = '{32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
      load_iv(v);
      ct_we = 1'b1; ct_idx = 2'd0; ct_in = 32'h22222222;
      @(posedge clk); @(negedge clk);
      ct_we = 1'b0;
      ecb = 1'b1;
      e = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
      feed(e, 4);
      drain(e, 1'b0);
      ecb = 1'b0;
      v = '{32'h0, 32'h0, 32'h0, 32'h0};
      feed(v, 4);
      e = '{32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
      drain(e, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
